// File: rtl/seg7_bcd_ctrl_pkg.sv
// Shared types, constants and helpers for the seven-segment BCD display controller.
package seg7_pkg;

    localparam logic [3:0] SEG7_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } seg7_state_e;

    // Bit offset of the least significant bit of digit k in a packed nibble vector.
    function automatic int unsigned dig_lsb(input int unsigned k);
        return 4 * k;
    endfunction

    // Largest value representable in n decimal digits.
    function automatic logic [63:0] pow10_minus1(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/seg7_bcd_ctrl_if.sv
// Handshake and display-output bundle between the PIO side and the BCD controller.
interface seg7_bcd_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BIN_WIDTH  = 27
);
    logic                    iVALID;
    logic                    oREADY;
    logic [BIN_WIDTH-1:0]    iDATA;
    logic [4*NUM_DIGITS-1:0] oDIG;
    logic                    oOVF;
    logic                    oDONE;

    modport master (
        output iVALID, iDATA,
        input  oREADY, oDIG, oOVF, oDONE
    );

    modport slave (
        input  iVALID, iDATA,
        output oREADY, oDIG, oOVF, oDONE
    );
endinterface

// File: rtl/seg7_bcd_ctrl_dd_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next binary bit.
module seg7_dd_step
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    input  logic                    bin_msb_i,
    output logic [4*NUM_DIGITS-1:0] bcd_c
);
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;

    logic [BCD_W-1:0] adj;
    logic [3:0]       nib;

    always_comb begin
        adj = bcd_i;
        nib = 4'd0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            nib = bcd_i[dig_lsb(k) +: 4];
            if (nib >= 4'd5) begin
                adj[dig_lsb(k) +: 4] = nib + 4'd3;
            end
        end
        bcd_c = {adj[BCD_W-2:0], bin_msb_i};
    end
endmodule

// File: rtl/seg7_bcd_ctrl.sv
// Binary-to-BCD display controller for the seven-segment bank (iterative double-dabble).
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_bcd_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BIN_WIDTH  = 27
) (
    input logic           iCLK,
    input logic           iRST,
    seg7_bcd_ctrl_if.slave bus
);
    localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = pow10_minus1(NUM_DIGITS);

    seg7_state_e          state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     dig_q, dig_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;

    logic [BCD_W-1:0]     bcd_step_c;
    logic [BCD_W-1:0]     codes_c;
    logic                 accept_c;
    logic                 over_c;
    logic                 seen_c;

    seg7_dd_step #(.NUM_DIGITS(NUM_DIGITS)) u_step (
        .bcd_i     (bcd_q),
        .bin_msb_i (bin_q[BIN_WIDTH-1]),
        .bcd_c     (bcd_step_c)
    );

    assign accept_c = bus.iVALID && ready_q;
    assign over_c   = (64'(bus.iDATA) > MAX_VAL);

    // Final digit codes: overflow blanks everything; optionally blank leading zeros.
    always_comb begin
        codes_c = bcd_q;
        seen_c  = 1'b0;
        if (ovf_pend_q) begin
            codes_c = {NUM_DIGITS{SEG7_BLANK}};
        end else begin
            for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
                if (bcd_q[dig_lsb(k) +: 4] != 4'd0 || k == 0) begin
                    seen_c = 1'b1;
                end
`ifdef SEG7_LZB_EN
                if (!seen_c) begin
                    codes_c[dig_lsb(k) +: 4] = SEG7_BLANK;
                end
`endif
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        dig_d      = dig_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        ready_d    = ready_q;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    bin_d      = bus.iDATA;
                    bcd_d      = '0;
                    ovf_pend_d = over_c;
                    cnt_d      = CNT_W'(BIN_WIDTH);
                    ready_d    = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_step_c;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                dig_d   = codes_c;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            dig_q      <= {NUM_DIGITS{SEG7_BLANK}};
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            dig_q      <= dig_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.oREADY = ready_q;
    assign bus.oDIG   = dig_q;
    assign bus.oOVF   = ovf_q;
    assign bus.oDONE  = done_q;
endmodule
